accel_spi_responder: RTL

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

---
 rtl/accel_spi_pkg.sv | 43 ++++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/accel_spi_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/accel_spi_pkg.sv
// Shared constants, state encoding and helpers for the
// accelerometer SPI responder.
package accel_spi_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
    localparam logic [7:0] ADDR_PARTID     = 8'h02;
    localparam logic [7:0] ADDR_XDATA      = 8'h08;
    localparam logic [7:0] ADDR_YDATA      = 8'h09;
    localparam logic [7:0] ADDR_ZDATA      = 8'h0A;
    localparam logic [7:0] ADDR_XL         = 8'h0E;
    localparam logic [7:0] ADDR_XH         = 8'h0F;
    localparam logic [7:0] ADDR_YL         = 8'h10;
    localparam logic [7:0] ADDR_YH         = 8'h11;
    localparam logic [7:0] ADDR_ZL         = 8'h12;
    localparam logic [7:0] ADDR_ZH         = 8'h13;
    localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
    localparam logic [7:0] ADDR_RW_FIRST   = 8'h20;
    localparam logic [7:0] ADDR_RW_LAST    = 8'h2D;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

    localparam logic [7:0] DEVID_MST_VAL = 8'h1D;
    localparam int         RW_COUNT      = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA_WR,
        ST_DATA_RD,
        ST_IGNORE
    } state_t;

    // High byte of a 12-bit sample, sign-extended to 8 bits.
    function automatic logic [7:0] hi_byte(input logic [11:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    // Synchronize, then keep one more stage for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= INIT;
            sync_q <= INIT;
            prev_q <= INIT;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 register responder modelling an
// accelerometer: ID, sample data and R/W control bytes.
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter logic [7:0] DEVID_AD = 8'hAD,
    parameter logic [7:0] PARTID   = 8'hF2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_accel_sclk,
    input  logic        i_accel_cs_n,
    input  logic        i_accel_mosi,
    output logic        o_accel_miso,
    input  logic [35:0] i_sample,
    input  logic        i_sample_valid,
    output logic        o_measure
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.INIT(1'b0)) u_sclk (
        .clk(clk), .rstn(rstn), .din(i_accel_sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.INIT(1'b1)) u_cs (
        .clk(clk), .rstn(rstn), .din(i_accel_cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.INIT(1'b0)) u_mosi (
        .clk(clk), .rstn(rstn), .din(i_accel_mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, cs_rise, mosi_rise, mosi_fall};

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_in_q, shift_out_q, addr_q;
    logic        rd_q, miso_q, measure_q;
    logic [7:0]  rw_q [RW_COUNT];
    logic [35:0] live_q, shadow_q;
    logic [1:0]  flush_q;
    logic        armed_q;

    logic [7:0]  byte_in, rd_addr, rd_data;
    logic        last_bit, start;
    logic [11:0] xs, ys, zs;

    assign byte_in  = {shift_in_q[6:0], mosi_s};
    assign last_bit = sclk_rise && (bit_cnt_q == 3'd7) && !cs_s;
    assign start    = (state_q == ST_IDLE) && cs_fall && armed_q;
    assign xs = shadow_q[11:0];
    assign ys = shadow_q[23:12];
    assign zs = shadow_q[35:24];

    // Ignore the cs_n fall caused by the synchronizer leaving
    // its reset level; arm only once cs_n is really seen high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_q <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
            if (flush_q == 2'd3 && cs_s) armed_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; cs_n high always aborts to IDLE.
    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) state_d = ST_CMD;
                ST_CMD: if (last_bit) begin
                    if (byte_in == CMD_WRITE || byte_in == CMD_READ)
                        state_d = ST_ADDR;
                    else
                        state_d = ST_IGNORE;
                end
                ST_ADDR: if (last_bit)
                    state_d = rd_q ? ST_DATA_RD : ST_DATA_WR;
                default: state_d = state_q;
            endcase
        end
    end

    // Register read mux; address is the next byte to present.
    always_comb begin
        rd_addr = (state_q == ST_ADDR) ? byte_in : addr_q + 8'd1;
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID_AD:  rd_data = DEVID_AD;
            ADDR_DEVID_MST: rd_data = DEVID_MST_VAL;
            ADDR_PARTID:    rd_data = PARTID;
            ADDR_XDATA:     rd_data = xs[11:4];
            ADDR_YDATA:     rd_data = ys[11:4];
            ADDR_ZDATA:     rd_data = zs[11:4];
            ADDR_XL:        rd_data = xs[7:0];
            ADDR_XH:        rd_data = hi_byte(xs);
            ADDR_YL:        rd_data = ys[7:0];
            ADDR_YH:        rd_data = hi_byte(ys);
            ADDR_ZL:        rd_data = zs[7:0];
            ADDR_ZH:        rd_data = hi_byte(zs);
            default: begin
                if (rd_addr >= ADDR_RW_FIRST && rd_addr <= ADDR_RW_LAST)
                    rd_data = rw_q[rd_addr[3:0]];
            end
        endcase
    end

    // Shift, address, register file and sample datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= 8'h00;
            addr_q      <= 8'h00;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            measure_q   <= 1'b0;
            live_q      <= 36'd0;
            shadow_q    <= 36'd0;
            for (int i = 0; i < RW_COUNT; i++) rw_q[i] <= 8'h00;
        end else begin
            if (i_sample_valid) live_q <= i_sample;
            if (start) begin
                shadow_q  <= live_q;
                bit_cnt_q <= 3'd0;
            end
            if (state_q != ST_IDLE && !cs_s && sclk_rise) begin
                shift_in_q <= byte_in;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
            end
            if (state_q != ST_DATA_RD || cs_s) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                miso_q      <= shift_out_q[7];
                shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
            if (last_bit) begin
                case (state_q)
                    ST_CMD: rd_q <= (byte_in == CMD_READ);
                    ST_ADDR: begin
                        addr_q <= byte_in;
                        if (rd_q) shift_out_q <= rd_data;
                    end
                    ST_DATA_RD: begin
                        addr_q      <= addr_q + 8'd1;
                        shift_out_q <= rd_data;
                    end
                    ST_DATA_WR: begin
                        addr_q <= addr_q + 8'd1;
                        if (addr_q == ADDR_SOFT_RESET &&
                            byte_in == SOFT_RESET_KEY) begin
                            for (int i = 0; i < RW_COUNT; i++)
                                rw_q[i] <= 8'h00;
                            measure_q <= 1'b0;
                        end else if (addr_q >= ADDR_RW_FIRST &&
                                     addr_q <= ADDR_RW_LAST) begin
                            rw_q[addr_q[3:0]] <= byte_in;
                            if (addr_q == ADDR_POWER_CTL)
                                measure_q <= (byte_in[1:0] == 2'b10);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_accel_miso = miso_q;
    assign o_measure    = measure_q;

endmodule
